// File: rtl/regfile_scoreboard.sv
// Integer register file with a per-register busy scoreboard for the pipelined core.
// NREAD combinational read ports, one synchronous write port, a debug read port and
// a busy bit per register that decode uses to stall on RAW hazards.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle writeback data
// (and a cleared busy flag) onto the read ports. dbg_data is never bypassed.
module regfile_scoreboard #(
    parameter int unsigned     XLEN       = 32,
    parameter int unsigned     NREGS      = 32,
    parameter int unsigned     NREAD      = 2,
    parameter logic [XLEN-1:0] STACK_ADDR = 'h700
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NREAD*$clog2(NREGS)-1:0]     raddr,
    output logic [NREAD*XLEN-1:0]              rdata,
    output logic [NREAD-1:0]                   rbusy,
    input  logic                               issue_valid,
    input  logic [$clog2(NREGS)-1:0]           issue_rd,
    input  logic                               we,
    input  logic [$clog2(NREGS)-1:0]           waddr,
    input  logic [XLEN-1:0]                    wdata,
    input  logic [$clog2(NREGS)-1:0]           dbg_addr,
    output logic [XLEN-1:0]                    dbg_data,
    output logic [NREGS-1:0]                   busy_vec
);

    localparam int unsigned AW = $clog2(NREGS);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Next register contents: a single writeback, register 0 is never written.
    always_comb begin
        regs_d = regs_q;
        if (we && (waddr != '0)) begin
            regs_d[waddr] = wdata;
        end
    end

    // Next scoreboard: a new issue beats a writeback to the same register.
    always_comb begin
        busy_d = busy_q;
        for (int unsigned r = 0; r < NREGS; r++) begin
            if (issue_valid && (issue_rd == AW'(r))) begin
                busy_d[r] = 1'b1;
            end else if (we && (waddr == AW'(r))) begin
                busy_d[r] = 1'b0;
            end
        end
        busy_d[0] = 1'b0;
    end

    // State update; reset overrides any concurrent write or issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                regs_q[r] <= (r == 2) ? STACK_ADDR : '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    // Combinational read ports, optionally forwarding the writeback in flight.
    always_comb begin
        rdata = '0;
        rbusy = '0;
        for (int unsigned i = 0; i < NREAD; i++) begin
            if (raddr[i*AW +: AW] != '0) begin
                rdata[i*XLEN +: XLEN] = regs_q[raddr[i*AW +: AW]];
            end
            rbusy[i] = busy_q[raddr[i*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
            // A same-cycle issue to this register only shows up next cycle.
            if (we && (waddr != '0) && (waddr == raddr[i*AW +: AW])) begin
                rdata[i*XLEN +: XLEN] = wdata;
                rbusy[i]              = 1'b0;
            end
`endif
        end
    end

    // Debug/trace observation of registered state only.
    always_comb begin
        dbg_data = regs_q[dbg_addr];
        busy_vec = busy_q;
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: one default instance (XLEN=32, NREAD=2) and one
// wide instance (XLEN=64, NREAD=3) driven by the same stimulus and checked side by side.
module tb_regfile_scoreboard;

`ifdef REGFILE_BYPASS_EN
    localparam bit Bypass = 1'b1;
`else
    localparam bit Bypass = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rd_addr [3];
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        we;
    logic [4:0]  waddr;
    logic [63:0] wdata;
    logic [4:0]  dbg_addr;

    logic [9:0]   raddr_a;
    logic [63:0]  rdata_a;
    logic [1:0]   rbusy_a;
    logic [31:0]  dbg_a;
    logic [31:0]  busy_a;
    logic [14:0]  raddr_b;
    logic [191:0] rdata_b;
    logic [2:0]   rbusy_b;
    logic [63:0]  dbg_b;
    logic [31:0]  busy_b;

    int n_checks = 0;
    int n_fail   = 0;

    assign raddr_a = {rd_addr[1], rd_addr[0]};
    assign raddr_b = {rd_addr[2], rd_addr[1], rd_addr[0]};

    always #5 clk = ~clk;

    regfile_scoreboard u_dut_a (
        .clk         (clk),
        .rst         (rst),
        .raddr       (raddr_a),
        .rdata       (rdata_a),
        .rbusy       (rbusy_a),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .we          (we),
        .waddr       (waddr),
        .wdata       (wdata[31:0]),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_a),
        .busy_vec    (busy_a)
    );

    regfile_scoreboard #(
        .XLEN  (64),
        .NREAD (3)
    ) u_dut_b (
        .clk         (clk),
        .rst         (rst),
        .raddr       (raddr_b),
        .rdata       (rdata_b),
        .rbusy       (rbusy_b),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .we          (we),
        .waddr       (waddr),
        .wdata       (wdata),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_b),
        .busy_vec    (busy_b)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Same expectation on both instances; the 32-bit one sees the low half.
    task automatic check_both(input string tag, input logic [63:0] got_a,
                              input logic [63:0] got_b, input logic [63:0] exp);
        check_val({tag, "/x32"}, got_a, {32'h0, exp[31:0]});
        check_val({tag, "/x64"}, got_b, exp);
    endtask

    function automatic logic [63:0] rda(input int i);
        return {32'h0, rdata_a[i*32 +: 32]};
    endfunction

    function automatic logic [63:0] rdb(input int i);
        return rdata_b[i*64 +: 64];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst         = 1'b0;
        we          = 1'b0;
        issue_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; issue_valid = 1'b0; issue_rd = '0;
        waddr = '0; wdata = '0; dbg_addr = '0;
        for (int i = 0; i < 3; i++) rd_addr[i] = '0;

        // 1: reset state
        tick(); idle();
        dbg_addr = 5'd2; rd_addr[0] = 5'd2; #1;
        check_both("rst_dbg2", {32'h0, dbg_a}, dbg_b, 64'h700);
        check_both("rst_rd2", rda(0), rdb(0), 64'h700);
        dbg_addr = 5'd5; #1;
        check_both("rst_dbg5", {32'h0, dbg_a}, dbg_b, 64'h0);
        check_both("rst_busy", {32'h0, busy_a}, {32'h0, busy_b}, 64'h0);

        // 2: write then read; write to x0 is discarded
        we = 1'b1; waddr = 5'd5; wdata = 64'hCAFEF00D_DEADBEEF; rd_addr[0] = 5'd5;
        tick(); idle(); #1;
        check_both("wr5_rd0", rda(0), rdb(0), 64'hCAFEF00D_DEADBEEF);
        check_both("wr5_busy", {32'h0, busy_a}, {32'h0, busy_b}, 64'h0);
        we = 1'b1; waddr = 5'd0; wdata = '1;
        tick(); idle(); rd_addr[0] = 5'd0; dbg_addr = 5'd0; #1;
        check_both("wr0_rd0", rda(0), rdb(0), 64'h0);
        check_both("wr0_dbg", {32'h0, dbg_a}, dbg_b, 64'h0);

        // 3: scoreboard set then clear
        issue_valid = 1'b1; issue_rd = 5'd7;
        tick(); idle(); rd_addr[1] = 5'd7; rd_addr[2] = 5'd5; #1;
        check_both("iss7_busy", {63'h0, busy_a[7]}, {63'h0, busy_b[7]}, 64'h1);
        check_both("iss7_rbusy1", {63'h0, rbusy_a[1]}, {63'h0, rbusy_b[1]}, 64'h1);
        check_val("dup_rd2/x64", rdb(2), 64'hCAFEF00D_DEADBEEF);
        we = 1'b1; waddr = 5'd7; wdata = 64'h0000_0001_0000_0077;
        tick(); idle(); #1;
        check_both("wb7_busy", {32'h0, busy_a}, {32'h0, busy_b}, 64'h0);
        check_both("wb7_rbusy1", {63'h0, rbusy_a[1]}, {63'h0, rbusy_b[1]}, 64'h0);
        check_both("wb7_rd1", rda(1), rdb(1), 64'h0000_0001_0000_0077);

        // 4: issue and writeback to the same busy register
        issue_valid = 1'b1; issue_rd = 5'd9;
        tick(); idle();
        issue_valid = 1'b1; issue_rd = 5'd9; we = 1'b1; waddr = 5'd9; wdata = 64'h1;
        tick(); idle(); dbg_addr = 5'd9; #1;
        check_both("col9_busy", {32'h0, busy_a}, {32'h0, busy_b}, 64'h200);
        check_both("col9_data", {32'h0, dbg_a}, dbg_b, 64'h1);

        // 5: bypass; R10=0x33 and busy before the probed cycle
        issue_valid = 1'b1; issue_rd = 5'd10; we = 1'b1; waddr = 5'd10; wdata = 64'h33;
        tick(); idle();
        rd_addr[0] = 5'd10; dbg_addr = 5'd10;
        we = 1'b1; waddr = 5'd10; wdata = 64'h1111_0000_0000_0055; #1;
        check_both("byp_rd0", rda(0), rdb(0), Bypass ? 64'h1111_0000_0000_0055 : 64'h33);
        check_both("byp_rbusy0", {63'h0, rbusy_a[0]}, {63'h0, rbusy_b[0]},
                   Bypass ? 64'h0 : 64'h1);
        check_both("byp_dbg", {32'h0, dbg_a}, dbg_b, 64'h33);
        tick(); idle(); #1;
        check_both("byp_after", rda(0), rdb(0), 64'h1111_0000_0000_0055);
        // Same-cycle issue and write: busy still reads 0 under bypass
        rd_addr[1] = 5'd10;
        issue_valid = 1'b1; issue_rd = 5'd10; we = 1'b1; waddr = 5'd10; wdata = 64'h66; #1;
        check_both("bypiss_rd1", rda(1), rdb(1), Bypass ? 64'h66 : 64'h1111_0000_0000_0055);
        check_both("bypiss_rbusy1", {63'h0, rbusy_a[1]}, {63'h0, rbusy_b[1]}, 64'h0);
        tick(); idle(); #1;
        check_both("bypiss_next", {63'h0, rbusy_a[1]}, {63'h0, rbusy_b[1]}, 64'h1);

        // 6: reset with pending busy bits; concurrent write/issue ignored
        issue_valid = 1'b1; issue_rd = 5'd3; we = 1'b1; waddr = 5'd3; wdata = 64'hAB;
        tick(); idle();
        issue_valid = 1'b1; issue_rd = 5'd4; tick(); idle();
        issue_valid = 1'b1; issue_rd = 5'd6; tick(); idle(); #1;
        check_both("pre_rst_busy", {32'h0, busy_a}, {32'h0, busy_b}, 64'h658);
        rst = 1'b1; we = 1'b1; waddr = 5'd8; wdata = 64'hBAD; issue_valid = 1'b1; issue_rd = 5'd8;
        tick(); idle(); dbg_addr = 5'd3; #1;
        check_both("mrst_busy", {32'h0, busy_a}, {32'h0, busy_b}, 64'h0);
        check_both("mrst_r3", {32'h0, dbg_a}, dbg_b, 64'h0);
        dbg_addr = 5'd8; #1;
        check_both("mrst_r8", {32'h0, dbg_a}, dbg_b, 64'h0);
        dbg_addr = 5'd2; #1;
        check_both("mrst_r2", {32'h0, dbg_a}, dbg_b, 64'h700);
        // Late writeback after reset still lands; busy stays clear
        we = 1'b1; waddr = 5'd4; wdata = 64'h44;
        tick(); idle(); dbg_addr = 5'd4; #1;
        check_both("late_wb_r4", {32'h0, dbg_a}, dbg_b, 64'h44);
        check_both("late_wb_busy", {32'h0, busy_a}, {32'h0, busy_b}, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
